// File: rtl/ram8.sv
// ram8: 8 x 16-bit register file assembled from the gate library (dmux8way strobes, mux8way16 read).
// Writes land on the rising clock edge; reads are combinational; there is no flow control.

module ram8 (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic [2:0]  address,
  output logic [15:0] out
);

  logic [7:0]       word_load;
  logic [7:0][15:0] word_q;

  dmux8way u_strobe (
    .in  (load),
    .sel (address),
    .out (word_load)
  );

  for (genvar w = 0; w < 8; w++) begin : g_word
    register16 u_word (
      .clock (clock),
      .reset (reset),
      .in    (in),
      .load  (word_load[w]),
      .out   (word_q[w])
    );
  end

  mux8way16 u_read (
    .in  (word_q),
    .sel (address),
    .out (out)
  );

endmodule

// Primitive gates; everything below is composed only from these and the dff.
module not_gate (
  input  logic in,
  output logic out
);
  assign out = ~in;
endmodule

module and_gate (
  input  logic a,
  input  logic b,
  output logic out
);
  assign out = a & b;
endmodule

module or_gate (
  input  logic a,
  input  logic b,
  output logic out
);
  assign out = a | b;
endmodule

// 2:1 mux: out = sel ? b : a.
module mux_gate (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic out
);
  logic sel_n, a_term, b_term;

  not_gate u_not (.in(sel), .out(sel_n));
  and_gate u_and_a (.a(a), .b(sel_n), .out(a_term));
  and_gate u_and_b (.a(b), .b(sel), .out(b_term));
  or_gate  u_or (.a(a_term), .b(b_term), .out(out));
endmodule

// 1:2 demux: input routed to a when sel=0, to b when sel=1.
module dmux_gate (
  input  logic in,
  input  logic sel,
  output logic a,
  output logic b
);
  logic sel_n;

  not_gate u_not (.in(sel), .out(sel_n));
  and_gate u_and_a (.a(in), .b(sel_n), .out(a));
  and_gate u_and_b (.a(in), .b(sel), .out(b));
endmodule

module dmux4way (
  input  logic       in,
  input  logic [1:0] sel,
  output logic [3:0] out
);
  logic lo, hi;

  dmux_gate u_top (.in(in), .sel(sel[1]), .a(lo), .b(hi));
  dmux_gate u_lo (.in(lo), .sel(sel[0]), .a(out[0]), .b(out[1]));
  dmux_gate u_hi (.in(hi), .sel(sel[0]), .a(out[2]), .b(out[3]));
endmodule

// One-hot write strobe: exactly out[sel] follows in, all others stay low.
module dmux8way (
  input  logic       in,
  input  logic [2:0] sel,
  output logic [7:0] out
);
  logic lo, hi;

  dmux_gate u_top (.in(in), .sel(sel[2]), .a(lo), .b(hi));
  dmux4way  u_lo (.in(lo), .sel(sel[1:0]), .out(out[3:0]));
  dmux4way  u_hi (.in(hi), .sel(sel[1:0]), .out(out[7:4]));
endmodule

module mux16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sel,
  output logic [15:0] out
);
  for (genvar i = 0; i < 16; i++) begin : g_bit
    mux_gate u_mux (.a(a[i]), .b(b[i]), .sel(sel), .out(out[i]));
  end
endmodule

module mux4way16 (
  input  logic [3:0][15:0] in,
  input  logic [1:0]       sel,
  output logic [15:0]      out
);
  logic [15:0] lo, hi;

  mux16 u_lo (.a(in[0]), .b(in[1]), .sel(sel[0]), .out(lo));
  mux16 u_hi (.a(in[2]), .b(in[3]), .sel(sel[0]), .out(hi));
  mux16 u_top (.a(lo), .b(hi), .sel(sel[1]), .out(out));
endmodule

module mux8way16 (
  input  logic [7:0][15:0] in,
  input  logic [2:0]       sel,
  output logic [15:0]      out
);
  logic [15:0] lo, hi;

  mux4way16 u_lo (.in(in[3:0]), .sel(sel[1:0]), .out(lo));
  mux4way16 u_hi (.in(in[7:4]), .sel(sel[1:0]), .out(hi));
  mux16     u_top (.a(lo), .b(hi), .sel(sel[2]), .out(out));
endmodule

// Only storage element in the block; reset is synchronous and overrides d.
module dff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  always_ff @(posedge clock) begin
    if (reset) q <= 1'b0;
    else       q <= d;
  end
endmodule

// One stored bit: the mux recirculates q when load is low.
module bit_cell (
  input  logic clock,
  input  logic reset,
  input  logic in,
  input  logic load,
  output logic out
);
  logic d;

  mux_gate u_hold (.a(out), .b(in), .sel(load), .out(d));
  dff      u_dff (.clock(clock), .reset(reset), .d(d), .q(out));
endmodule

module register16 (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  output logic [15:0] out
);
  for (genvar i = 0; i < 16; i++) begin : g_bit
    bit_cell u_bit (
      .clock (clock),
      .reset (reset),
      .in    (in[i]),
      .load  (load),
      .out   (out[i])
    );
  end
endmodule

// File: tb/tb_ram8.sv
// Scoreboard bench for ram8: expected read data is queued when stimulus is applied and popped when out is sampled.
module tb_ram8;

  logic        clock;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic [15:0] out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] model [8];
  logic [15:0] exp_q [$];

  ram8 dut (
    .clock   (clock),
    .reset   (reset),
    .in      (in),
    .load    (load),
    .address (address),
    .out     (out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Compare the current out against the oldest queued expectation.
  task automatic pop_chk(input string tag);
    logic [15:0] expv;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %h", tag, out);
    end else begin
      expv = exp_q.pop_front();
      chk(tag, out, expv);
    end
  endtask

  // One clock: drive at negedge, check pre-edge read, clock it, check post-edge read.
  task automatic step(input logic r, input logic l, input logic [2:0] a,
                      input logic [15:0] d, input string tag);
    @(negedge clock);
    reset = r; load = l; address = a; in = d;
    #1;
    exp_q.push_back(model[a]);
    pop_chk($sformatf("%s_pre", tag));
    @(posedge clock);
    if (r) begin
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    end else if (l) begin
      model[a] = d;
    end
    #1;
    exp_q.push_back(model[a]);
    pop_chk($sformatf("%s_post", tag));
  endtask

  // Combinational read with an explicitly supplied expected value.
  task automatic rd(input logic [2:0] a, input logic [15:0] expv, input string tag);
    @(negedge clock);
    reset = 1'b0; load = 1'b0; address = a; in = 16'h0000;
    #1;
    exp_q.push_back(expv);
    pop_chk($sformatf("%s_a%0d", tag, a));
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; address = 3'd0; in = 16'h0000;
    for (int i = 0; i < 8; i++) model[i] = 16'hxxxx;
    repeat (2) @(posedge clock);
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;

    for (int k = 0; k < 8; k++) rd(3'(k), 16'h0000, "reset_sweep");

    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 3'(k), 16'(16'h1111 * k), "wr_pattern");
    for (int k = 0; k < 8; k++) rd(3'(k), 16'(16'h1111 * k), "rd_pattern");

    step(1'b0, 1'b1, 3'd5, 16'hAAAA, "wr5_aaaa");
    @(negedge clock);
    load = 1'b1; address = 3'd5; in = 16'h5555;
    #1;
    chk("rdw_before_edge", out, 16'hAAAA);
    @(posedge clock);
    #1;
    chk("rdw_after_edge", out, 16'h5555);
    model[5] = 16'h5555;

    for (int e = 0; e < 4; e++)
      for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 3'(k), 16'hFFFF, "hold_ffff");
    for (int k = 0; k < 8; k++)
      rd(3'(k), (k == 5) ? 16'h5555 : 16'(16'h1111 * k), "rd_after_hold");

    // Inputs wiggle during the low phase; only what is present at the edge counts.
    @(negedge clock);
    load = 1'b1; address = 3'd3; in = 16'hDEAD;
    #2 address = 3'd6; in = 16'hF00D;
    #1 load = 1'b0;
    @(posedge clock);
    #1;
    rd(3'd3, 16'h3333, "midcycle");
    rd(3'd6, 16'h6666, "midcycle");

    step(1'b0, 1'b1, 3'd4, 16'h0001, "b2b_1");
    step(1'b0, 1'b1, 3'd4, 16'h0002, "b2b_2");
    step(1'b0, 1'b1, 3'd4, 16'h0003, "b2b_3");
    rd(3'd4, 16'h0003, "b2b_last");

    step(1'b1, 1'b1, 3'd2, 16'hBEEF, "reset_vs_load");
    for (int k = 0; k < 8; k++) rd(3'(k), 16'h0000, "rd_after_rst_load");

    step(1'b0, 1'b1, 3'd1, 16'h1234, "seq_w1");
    step(1'b0, 1'b1, 3'd6, 16'h5678, "seq_w6");
    step(1'b1, 1'b0, 3'd1, 16'h0000, "seq_reset");
    step(1'b0, 1'b1, 3'd3, 16'h9ABC, "seq_w3");
    rd(3'd1, 16'h0000, "seq_cleared");
    rd(3'd6, 16'h0000, "seq_cleared");
    rd(3'd3, 16'h9ABC, "seq_kept");

    for (int k = 1; k < 7; k++) step(1'b0, 1'b1, 3'(k), 16'(16'hC000 + k), "bnd_fill");
    step(1'b0, 1'b1, 3'd0, 16'h8000, "bnd_w0");
    step(1'b0, 1'b1, 3'd7, 16'h7FFF, "bnd_w7");
    rd(3'd0, 16'h8000, "bnd_rd");
    rd(3'd7, 16'h7FFF, "bnd_rd");
    for (int k = 1; k < 7; k++) rd(3'(k), 16'(16'hC000 + k), "bnd_mid");

    for (int n = 0; n < 60; n++)
      step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 16'($urandom), "rand");
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      reset = 1'b0; load = 1'b0; address = 3'(k);
      #1;
      exp_q.push_back(model[k]);
      pop_chk($sformatf("rand_final_a%0d", k));
    end

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
